// File: rtl/tx_pattern_pkg.sv
// Shared types and constants for the Tx pattern generator.
// Holds pattern modes, FSM states and standard PRBS tap masks.
package tx_pattern_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      PAT_PRBS  = 2'd0,
      PAT_FIXED = 2'd1,
      PAT_CLOCK = 2'd2,
      PAT_ZERO  = 2'd3
   } tx_pat_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } tx_pat_state_e;

   // Fibonacci tap masks, bit i set = tap on state[i]
   localparam logic [6:0]  PRBS7_EQN  = 7'h60;
   localparam logic [14:0] PRBS15_EQN = 15'h6000;
   localparam logic [30:0] PRBS31_EQN = 31'h48000000;

endpackage

// File: rtl/prbs_par_step.sv
// Combinational W-step advance of a Fibonacci LFSR.
// word[k] is the feedback bit produced at step k (bit 0 = first serialized).
module prbs_par_step #(
   parameter int unsigned W = 16,
   parameter int unsigned N = 31
) (
   input  logic [N-1:0] state,
   input  logic [N-1:0] eqn,
   output logic [N-1:0] next_state,
   output logic [W-1:0] word
);

   logic [N-1:0] s;
   logic         fb;

   always_comb begin
      s    = state;
      fb   = 1'b0;
      word = '0;
      for (int unsigned k = 0; k < W; k++) begin
         fb      = ^(s & eqn);
         s       = {s[N-2:0], fb};
         word[k] = fb;
      end
      next_state = s;
   end

endmodule

// File: rtl/tx_prbs_word_gen.sv
// Parallel multi-mode pattern source for the Tx serializer path.
// One W-bit word per clk: PRBS, fixed, clock or zero, with counted error injection.
module tx_prbs_word_gen
   import tx_pattern_pkg::*;
#(
   parameter int unsigned W     = 16,
   parameter int unsigned N     = 31,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic [MODE_W-1:0]    cfg_mode,
   input  logic [N-1:0]         cfg_eqn,
   input  logic [N-1:0]         cfg_seed,
   input  logic [W-1:0]         cfg_pattern,
   input  logic                 cfg_inv,
   input  logic                 inj_err,
   input  logic [$clog2(W)-1:0] inj_pos,
   output logic [W-1:0]         dout,
   output logic                 dout_valid,
   output logic                 running,
   output logic                 seed_err,
   output logic [CNT_W-1:0]     inj_count
);

   localparam int unsigned PW = $clog2(W);

   tx_pat_state_e    state_q, state_d;
   tx_pat_mode_e     mode_q, mode_d;
   logic [N-1:0]     eqn_q, eqn_d;
   logic [W-1:0]     pattern_q, pattern_d;
   logic             inv_q, inv_d;
   logic [N-1:0]     lfsr_q, lfsr_d;
   logic             phase_q, phase_d;
   logic             pend_q, pend_d;
   logic [PW-1:0]    pos_q, pos_d;
   logic [W-1:0]     dout_q, dout_d;
   logic             valid_q, valid_d;
   logic             seed_err_q, seed_err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     prbs_next;
   logic [W-1:0]     prbs_word;
   logic [W-1:0]     clk_word;
   logic [W-1:0]     gen_word;
   logic [W-1:0]     flip_mask;

   prbs_par_step #(
      .W (W),
      .N (N)
   ) u_prbs_step (
      .state      (lfsr_q),
      .eqn        (eqn_q),
      .next_state (prbs_next),
      .word       (prbs_word)
   );

   // Raw pattern word for the captured mode, before inversion/injection
   always_comb begin
      clk_word = '0;
      for (int unsigned k = 0; k < W; k++) begin
         clk_word[k] = 1'(k % 2) ^ phase_q;
      end
      gen_word = '0;
      case (mode_q)
         PAT_PRBS:  gen_word = prbs_word;
         PAT_FIXED: gen_word = pattern_q;
         PAT_CLOCK: gen_word = clk_word;
         default:   gen_word = '0;
      endcase
      flip_mask = pend_q ? (W'(1) << pos_q) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= PAT_PRBS;
         eqn_q      <= '0;
         pattern_q  <= '0;
         inv_q      <= 1'b0;
         lfsr_q     <= '0;
         phase_q    <= 1'b0;
         pend_q     <= 1'b0;
         pos_q      <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         seed_err_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         eqn_q      <= eqn_d;
         pattern_q  <= pattern_d;
         inv_q      <= inv_d;
         lfsr_q     <= lfsr_d;
         phase_q    <= phase_d;
         pend_q     <= pend_d;
         pos_q      <= pos_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         seed_err_q <= seed_err_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      eqn_d      = eqn_q;
      pattern_d  = pattern_q;
      inv_d      = inv_q;
      lfsr_d     = lfsr_q;
      phase_d    = phase_q;
      pend_d     = 1'b0;
      pos_d      = pos_q;
      dout_d     = '0;
      valid_d    = 1'b0;
      seed_err_d = seed_err_q;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d   = ST_RUN;
            mode_d    = tx_pat_mode_e'(cfg_mode);
            eqn_d     = cfg_eqn;
            pattern_d = cfg_pattern;
            inv_d     = cfg_inv;
            phase_d   = 1'b0;
            cnt_d     = '0;
            // An all-zero seed would lock the PRBS at zero
            if (tx_pat_mode_e'(cfg_mode) == PAT_PRBS && cfg_seed == '0) begin
               lfsr_d     = N'(1);
               seed_err_d = 1'b1;
            end else begin
               lfsr_d     = cfg_seed;
               seed_err_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (start) state_d = ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase

      if (stop) state_d = ST_IDLE;

      // Emit a word only while staying in RUN; injection touches dout, never lfsr
      if (state_q == ST_RUN && state_d == ST_RUN) begin
         valid_d = 1'b1;
         dout_d  = gen_word ^ {W{inv_q}} ^ flip_mask;
         if (mode_q == PAT_PRBS) lfsr_d = prbs_next;
         phase_d = phase_q ^ 1'(W % 2);
         if (pend_q && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         pend_d = inj_err;
         pos_d  = inj_pos;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign running    = (state_q == ST_RUN);
   assign seed_err   = seed_err_q;
   assign inj_count  = cnt_q;

endmodule

// File: tb/tb_tx_prbs_word_gen.sv
// Randomized bench for tx_prbs_word_gen (W=16, N=7, CNT_W=3).
// Reference: serial linear-recurrence bitstream plus per-word injection model.
module tb_tx_prbs_word_gen;

   localparam int unsigned W     = 16;
   localparam int unsigned N     = 7;
   localparam int unsigned CNT_W = 3;
   localparam int unsigned SLEN  = 4224;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start, stop;
   logic [1:0]       cfg_mode;
   logic [N-1:0]     cfg_eqn, cfg_seed;
   logic [W-1:0]     cfg_pattern;
   logic             cfg_inv;
   logic             inj_err;
   logic [3:0]       inj_pos;
   logic [W-1:0]     dout;
   logic             dout_valid, running, seed_err;
   logic [CNT_W-1:0] inj_count;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int           m_mode;
   logic [N-1:0] m_eqn, m_seed;
   logic [W-1:0] m_pat;
   logic         m_inv;
   int           m_cnt;
   bit           strm [0:SLEN-1];
   logic [W-1:0] got_w [0:255];

   tx_prbs_word_gen #(.W(W), .N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .cfg_mode    (cfg_mode),
      .cfg_eqn     (cfg_eqn),
      .cfg_seed    (cfg_seed),
      .cfg_pattern (cfg_pattern),
      .cfg_inv     (cfg_inv),
      .inj_err     (inj_err),
      .inj_pos     (inj_pos),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .running     (running),
      .seed_err    (seed_err),
      .inj_count   (inj_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serial PRBS bitstream as a linear recurrence over its own history
   task automatic build_stream();
      logic [N-1:0] s;
      bit           x;
      s = (m_seed == '0) ? N'(1) : m_seed;
      for (int i = 0; i < int'(N); i++) strm[i] = s[N-1-i];
      for (int j = N; j < int'(SLEN); j++) begin
         x = 1'b0;
         for (int t = 0; t < int'(N); t++) if (m_eqn[t]) x ^= strm[j-1-t];
         strm[j] = x;
      end
   endtask

   function automatic logic [W-1:0] exp_word(input int i);
      logic [W-1:0] w;
      w = '0;
      case (m_mode)
         0: for (int k = 0; k < int'(W); k++) w[k] = strm[N + W*i + k];
         1: w = m_pat;
         2: for (int k = 0; k < int'(W); k++) w[k] = 1'((k + i*W) % 2);
         default: w = '0;
      endcase
      return w;
   endfunction

   task automatic set_cfg(input int mode, input logic [N-1:0] eqn, input logic [N-1:0] seed,
                          input logic [W-1:0] pat, input logic inv);
      cfg_mode = 2'(mode); cfg_eqn = eqn; cfg_seed = seed; cfg_pattern = pat; cfg_inv = inv;
      m_mode = mode; m_eqn = eqn; m_seed = seed; m_pat = pat; m_inv = inv; m_cnt = 0;
      build_stream();
   endtask

   // start pulse; returns one cycle into RUN, before the first valid word
   task automatic do_start(input int mode, input logic [N-1:0] eqn, input logic [N-1:0] seed,
                           input logic [W-1:0] pat, input logic inv);
      set_cfg(mode, eqn, seed, pat, inv);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
   endtask

   task automatic run_words(input int n, input int base, input bit rnd_inj, input string tag);
      logic         pend;
      logic [3:0]   ppos;
      logic [W-1:0] e;
      pend = 1'b0;
      ppos = '0;
      for (int i = 0; i < n; i++) begin
         inj_err = rnd_inj && (i != n-1) && ($urandom_range(3) == 0);
         inj_pos = 4'($urandom_range(15));
         tick();
         e = exp_word(base + i) ^ {W{m_inv}} ^ (pend ? (W'(1) << ppos) : W'(0));
         if (pend && m_cnt < 7) m_cnt++;
         got_w[i] = dout;
         check({tag, "_dout"}, dout, e);
         check({tag, "_valid"}, dout_valid, 1);
         check({tag, "_cnt"}, inj_count, m_cnt);
         pend = inj_err;
         ppos = inj_pos;
      end
      inj_err = 1'b0;
   endtask

   initial begin
      int nz;
      logic [W-1:0] d [0:5];
      logic [2:0]   c3;

      rst_n = 1'b0; start = 0; stop = 0; inj_err = 0; inj_pos = '0;
      set_cfg(0, 7'h60, 7'h7F, '0, 1'b0);
      #12;
      check("rst_dout", dout, 0);
      check("rst_valid", dout_valid, 0);
      check("rst_running", running, 0);
      check("rst_seed_err", seed_err, 0);
      check("rst_cnt", inj_count, 0);
      rst_n = 1'b1;
      tick();

      // PRBS7 with latency checks
      set_cfg(0, 7'h60, 7'h7F, '0, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("p7_lat_run0", running, 0);
      check("p7_lat_val0", dout_valid, 0);
      tick();
      check("p7_lat_run1", running, 1);
      check("p7_lat_val1", dout_valid, 0);
      run_words(130, 0, 1'b0, "p7");
      check("p7_first7", got_w[0][6:0], 7'b1000000);
      check("p7_period", got_w[127], got_w[0]);
      nz = 0;
      for (int i = 0; i < 130; i++) if (got_w[i] == '0) nz++;
      check("p7_nonzero", nz, 0);
      check("p7_seed_err", seed_err, 0);

      // fixed / inverted / clock modes
      do_start(1, 7'h60, 7'h11, 16'hC3A5, 1'b0);
      run_words(4, 0, 1'b0, "fix");
      check("fix_c3a5", got_w[3], 16'hC3A5);
      do_start(1, 7'h60, 7'h11, 16'hC3A5, 1'b1);
      run_words(4, 0, 1'b0, "finv");
      check("finv_3c5a", got_w[2], 16'h3C5A);
      do_start(2, 7'h60, 7'h11, 16'h0, 1'b0);
      run_words(4, 0, 1'b0, "clk");
      check("clk_aaaa", got_w[1], 16'hAAAA);

      // three back-to-back injections at bit 5
      do_start(1, 7'h60, 7'h11, 16'h0000, 1'b0);
      for (int i = 0; i < 6; i++) begin
         inj_err = (i < 3);
         inj_pos = 4'd5;
         tick();
         d[i] = dout;
      end
      inj_err = 1'b0;
      check("inj_w0", d[0], 16'h0000);
      check("inj_w1", d[1], 16'h0020);
      check("inj_w2", d[2], 16'h0020);
      check("inj_w3", d[3], 16'h0020);
      check("inj_w4", d[4], 16'h0000);
      check("inj_cnt3", inj_count, 3);

      // injection counter saturation
      do_start(1, 7'h60, 7'h11, 16'h0F0F, 1'b0);
      for (int i = 0; i < 11; i++) begin
         inj_err = (i < 10);
         inj_pos = 4'($urandom_range(15));
         tick();
      end
      inj_err = 1'b0;
      tick();
      check("inj_sat", inj_count, 7);

      // PRBS with random injections: errors must not disturb the sequence
      do_start(0, 7'h60, 7'h7F, '0, 1'b0);
      run_words(40, 0, 1'b1, "pinj");

      // zero seed falls back to seed 1
      do_start(0, 7'h60, 7'h00, '0, 1'b0);
      check("zs_seed_err", seed_err, 1);
      run_words(16, 0, 1'b0, "zs");
      do_start(0, 7'h60, 7'h01, '0, 1'b0);
      check("zs1_seed_err", seed_err, 0);
      run_words(16, 0, 1'b0, "zs1");

      // start+stop together: stop wins
      do_start(1, 7'h60, 7'h11, 16'h5555, 1'b0);
      run_words(3, 0, 1'b0, "ss");
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check("ss_valid", dout_valid, 0);
      check("ss_dout", dout, 0);
      check("ss_running", running, 0);
      tick();
      check("ss_idle", running, 0);

      // config change during RUN is ignored
      do_start(1, 7'h60, 7'h11, 16'h1234, 1'b0);
      run_words(3, 0, 1'b0, "rc_a");
      cfg_pattern = 16'hFFFF; cfg_inv = 1'b1; cfg_mode = 2'd3;
      run_words(3, 3, 1'b0, "rc_b");

      // async reset mid-RUN then restart from seed
      do_start(0, 7'h60, 7'h2B, '0, 1'b0);
      inj_err = 1'b1; inj_pos = 4'd2;
      tick();
      inj_err = 1'b0;
      tick();
      check("ar_cnt_pre", inj_count, 1);
      #2 rst_n = 1'b0;
      #1;
      check("ar_dout", dout, 0);
      check("ar_valid", dout_valid, 0);
      check("ar_cnt", inj_count, 0);
      check("ar_running", running, 0);
      #2 rst_n = 1'b1;
      tick();
      do_start(0, 7'h60, 7'h2B, '0, 1'b0);
      run_words(20, 0, 1'b0, "ar_rs");

      // randomized configurations
      for (int t = 0; t < 10; t++) begin
         do_start(int'($urandom_range(3)), 7'($urandom_range(127)),
                  ($urandom_range(4) == 0) ? 7'h00 : 7'($urandom_range(127)),
                  16'($urandom), 1'($urandom_range(1)));
         check("rnd_seed_err", seed_err, (m_mode == 0 && m_seed == '0) ? 1 : 0);
         run_words(24, 0, 1'b1, "rnd");
         if ($urandom_range(1) == 1) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            check("rnd_stop_valid", dout_valid, 0);
            check("rnd_stop_dout", dout, 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
